serial_add_sub_lanes: RTL and testbench



---
 rtl/serial_add_sub_lanes_pkg.sv | 16 +
 rtl/serial_add_sub_lanes_if.sv | 40 ++++
 rtl/serial_add_sub_lanes_lane.sv | 40 ++++
 rtl/serial_add_sub_lanes.sv | 103 ++++++++++
 tb/tb_serial_add_sub_lanes.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/serial_add_sub_lanes_pkg.sv
// rtl/serial_add_sub_lanes_pkg.sv - shared defaults, mode enum and counter sizing for the serial add/sub lanes
package serial_add_sub_pkg;

    localparam int DEFAULT_LANES = 4;
    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic {
        MODE_ADD = 1'b0,
        MODE_SUB = 1'b1
    } mode_e;

    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/serial_add_sub_lanes_if.sv
// rtl/serial_add_sub_lanes_if.sv - beat bus for the serial add/sub lanes; SERIAL_ADD_SUB_FRAME_ERR_EN adds out_frame_err
interface serial_add_sub_lanes_if
    import serial_add_sub_pkg::*;
#(
    parameter int LANES = DEFAULT_LANES
);

    logic             in_valid;
    logic             in_first;
    logic             in_sub;
    logic [LANES-1:0] a;
    logic [LANES-1:0] b;
    logic             out_valid;
    logic [LANES-1:0] out_sum;
    logic             out_last;
    logic [LANES-1:0] out_carry;
    logic [LANES-1:0] out_ovf;
`ifdef SERIAL_ADD_SUB_FRAME_ERR_EN
    logic             out_frame_err;

    modport master (
        output in_valid, in_first, in_sub, a, b,
        input  out_valid, out_sum, out_last, out_carry, out_ovf, out_frame_err
    );
    modport slave (
        input  in_valid, in_first, in_sub, a, b,
        output out_valid, out_sum, out_last, out_carry, out_ovf, out_frame_err
    );
`else
    modport master (
        output in_valid, in_first, in_sub, a, b,
        input  out_valid, out_sum, out_last, out_carry, out_ovf
    );
    modport slave (
        input  in_valid, in_first, in_sub, a, b,
        output out_valid, out_sum, out_last, out_carry, out_ovf
    );
`endif

endinterface

// File: rtl/serial_add_sub_lanes_lane.sv
// rtl/serial_add_sub_lanes_lane.sv - one bit-serial full adder lane with its carry register
module serial_add_sub_lane
    import serial_add_sub_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  en_i,
    input  logic  start_i,
    input  mode_e mode_i,
    input  logic  a_i,
    input  logic  b_i,
    output logic  sum_o,
    output logic  carry_o,
    output logic  ovf_o
);

    logic carry_q;
    logic carry_d;
    logic cin;
    logic b_eff;

    // Subtraction is A + ~B + 1: invert B and seed bit 0's carry-in with the mode.
    always_comb begin
        b_eff   = b_i ^ (mode_i == MODE_SUB);
        cin     = start_i ? (mode_i == MODE_SUB) : carry_q;
        sum_o   = a_i ^ b_eff ^ cin;
        carry_o = (a_i & b_eff) | (a_i & cin) | (b_eff & cin);
        ovf_o   = cin ^ carry_o;
        carry_d = en_i ? carry_o : carry_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            carry_q <= 1'b0;
        end else begin
            carry_q <= carry_d;
        end
    end

endmodule

// File: rtl/serial_add_sub_lanes.sv
// rtl/serial_add_sub_lanes.sv - multi-lane word-framed bit-serial adder/subtractor; SERIAL_ADD_SUB_FRAME_ERR_EN flags aborted words
module serial_add_sub_lanes
    import serial_add_sub_pkg::*;
#(
    parameter int LANES = DEFAULT_LANES,
    parameter int WIDTH = DEFAULT_WIDTH
)(
    input  logic                  clk,
    input  logic                  rst,
    serial_add_sub_lanes_if.slave bus
);

    localparam int            CW       = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic [CW-1:0]    bit_idx;
    mode_e            mode_q;
    mode_e            mode_d;
    logic             start;
    logic             last;
    logic [LANES-1:0] sum_c;
    logic [LANES-1:0] carry_c;
    logic [LANES-1:0] ovf_c;

    logic             out_valid_q;
    logic             out_last_q;
    logic [LANES-1:0] out_sum_q;
    logic [LANES-1:0] out_carry_q;
    logic [LANES-1:0] out_ovf_q;

    // in_first forces bit 0 even mid-word, so the abandoned word never reaches its last beat.
    always_comb begin
        start   = bus.in_first || (cnt_q == '0);
        bit_idx = start ? '0 : cnt_q;
        last    = bus.in_valid && (bit_idx == LAST_BIT);
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        if (bus.in_valid) begin
            if (start) begin
                mode_d = mode_e'(bus.in_sub);
            end
            cnt_d = (bit_idx == LAST_BIT) ? '0 : bit_idx + CW'(1);
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        serial_add_sub_lane u_lane (
            .clk     (clk),
            .rst     (rst),
            .en_i    (bus.in_valid),
            .start_i (start),
            .mode_i  (mode_d),
            .a_i     (bus.a[i]),
            .b_i     (bus.b[i]),
            .sum_o   (sum_c[i]),
            .carry_o (carry_c[i]),
            .ovf_o   (ovf_c[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            mode_q      <= MODE_ADD;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_sum_q   <= '0;
            out_carry_q <= '0;
            out_ovf_q   <= '0;
        end else begin
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            out_valid_q <= bus.in_valid;
            out_last_q  <= last;
            out_sum_q   <= bus.in_valid ? sum_c : '0;
            out_carry_q <= last ? carry_c : '0;
            out_ovf_q   <= last ? ovf_c : '0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_carry = out_carry_q;
    assign bus.out_ovf   = out_ovf_q;

`ifdef SERIAL_ADD_SUB_FRAME_ERR_EN
    logic frame_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= bus.in_valid && bus.in_first && (cnt_q != '0);
        end
    end

    assign bus.out_frame_err = frame_err_q;
`endif

endmodule

// File: tb/tb_serial_add_sub_lanes.sv
// tb/tb_serial_add_sub_lanes.sv - scoreboard bench for serial_add_sub_lanes; SERIAL_ADD_SUB_FRAME_ERR_EN also checks out_frame_err
module tb_serial_add_sub_lanes;

    localparam int LANES = 4;
    localparam int WIDTH = 16;

    typedef struct {
        logic             v;
        logic [LANES-1:0] sum;
        logic             last;
        logic [LANES-1:0] carry;
        logic [LANES-1:0] ovf;
        logic             ferr;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_add_sub_lanes_if #(.LANES(LANES)) bus ();

    serial_add_sub_lanes #(.LANES(LANES), .WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t                         exp_q[$];
    int                           checks = 0;
    int                           passed = 0;
    int                           fails  = 0;
    int                           last_seen;
    logic [LANES-1:0][WIDTH-1:0]  got_w;
    logic [LANES-1:0]             got_c;
    logic [LANES-1:0]             got_o;
    logic [LANES-1:0][WIDTH-1:0]  opa;
    logic [LANES-1:0][WIDTH-1:0]  opb;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic exp_t zero_exp();
        exp_t e;
        e.v = 1'b0; e.sum = '0; e.last = 1'b0; e.carry = '0; e.ovf = '0; e.ferr = 1'b0;
        return e;
    endfunction

    task automatic beat(input logic v, input logic f, input logic s,
                        input logic [LANES-1:0] av, input logic [LANES-1:0] bv, input exp_t e);
        exp_t x;
        bus.in_valid = v;
        bus.in_first = f;
        bus.in_sub   = s;
        bus.a        = av;
        bus.b        = bv;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        x = exp_q.pop_front();
        chk("out_valid", 32'(bus.out_valid), 32'(x.v));
        chk("out_sum",   32'(bus.out_sum),   32'(x.sum));
        chk("out_last",  32'(bus.out_last),  32'(x.last));
        chk("out_carry", 32'(bus.out_carry), 32'(x.carry));
        chk("out_ovf",   32'(bus.out_ovf),   32'(x.ovf));
`ifdef SERIAL_ADD_SUB_FRAME_ERR_EN
        chk("out_frame_err", 32'(bus.out_frame_err), 32'(x.ferr));
`endif
        if (bus.out_last) last_seen++;
    endtask

    // Word-level reference: full-width add/sub, then split into per-beat expectations.
    task automatic word(input logic sub, input int nbeats, input logic first,
                        input logic ferr_exp, input int gap_period);
        logic [LANES-1:0][WIDTH:0] r;
        logic [LANES-1:0]          cy;
        logic [LANES-1:0]          ov;
        logic [LANES-1:0]          av;
        logic [LANES-1:0]          bv;
        exp_t                      e;
        int                        c = 0;
        for (int l = 0; l < LANES; l++) begin
            if (sub) r[l] = {1'b0, opa[l]} + {1'b0, ~opb[l]} + 17'd1;
            else     r[l] = {1'b0, opa[l]} + {1'b0, opb[l]};
            cy[l] = r[l][WIDTH];
            if (sub) ov[l] = (opa[l][WIDTH-1] != opb[l][WIDTH-1]) && (r[l][WIDTH-1] != opa[l][WIDTH-1]);
            else     ov[l] = (opa[l][WIDTH-1] == opb[l][WIDTH-1]) && (r[l][WIDTH-1] != opa[l][WIDTH-1]);
        end
        for (int k = 0; k < nbeats; k++) begin
            if (gap_period > 0 && (c % gap_period) == gap_period - 1) begin
                beat(1'b0, 1'b0, 1'($urandom), LANES'($urandom), LANES'($urandom), zero_exp());
                c++;
            end
            e      = zero_exp();
            e.v    = 1'b1;
            e.last = (k == WIDTH - 1);
            e.ferr = (k == 0) && ferr_exp;
            for (int l = 0; l < LANES; l++) begin
                e.sum[l] = r[l][k];
                av[l]    = opa[l][k];
                bv[l]    = opb[l][k];
            end
            if (e.last) begin
                e.carry = cy;
                e.ovf   = ov;
            end
            beat(1'b1, (k == 0) && first, (k == 0) ? sub : ~sub, av, bv, e);
            for (int l = 0; l < LANES; l++) got_w[l][k] = bus.out_sum[l];
            if (k == WIDTH - 1) begin
                got_c = bus.out_carry;
                got_o = bus.out_ovf;
            end
            c++;
        end
    endtask

    task automatic set_ops(input logic [WIDTH-1:0] a0, input logic [WIDTH-1:0] b0,
                           input logic [WIDTH-1:0] a1, input logic [WIDTH-1:0] b1,
                           input logic [WIDTH-1:0] a2, input logic [WIDTH-1:0] b2);
        opa[0] = a0; opb[0] = b0;
        opa[1] = a1; opb[1] = b1;
        opa[2] = a2; opb[2] = b2;
        opa[3] = WIDTH'($urandom); opb[3] = WIDTH'($urandom);
    endtask

    initial begin
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_first = 1'b0;
        bus.in_sub   = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        last_seen    = 0;
        got_w        = '0;
        got_c        = '0;
        got_o        = '0;
        @(posedge clk);
        #1;
        beat(1'b1, 1'b1, 1'b1, '1, '1, zero_exp());
        rst = 1'b0;

        // Add with carry/overflow corner lanes.
        set_ops(16'h8192, 16'h2154, 16'h7FFF, 16'h0001, 16'hFFFF, 16'h0001);
        last_seen = 0;
        word(1'b0, WIDTH, 1'b1, 1'b0, 0);
        chk("t1_sum", 32'(got_w[0]), 32'h0000A2E6);
        chk("t1_cy",  32'(got_c[0]), 32'h0);
        chk("t1_ov",  32'(got_o[0]), 32'h0);
        chk("t3_sum", 32'(got_w[1]), 32'h00008000);
        chk("t3_ov",  32'(got_o[1]), 32'h1);
        chk("t3_cy",  32'(got_c[1]), 32'h0);
        chk("t3b_sum", 32'(got_w[2]), 32'h00000000);
        chk("t3b_cy",  32'(got_c[2]), 32'h1);
        chk("t3b_ov",  32'(got_o[2]), 32'h0);
        chk("t1_lastcnt", 32'(last_seen), 32'd1);

        // Subtract, back-to-back with no in_first.
        word(1'b1, WIDTH, 1'b0, 1'b0, 0);
        chk("t2_sum", 32'(got_w[0]), 32'h0000603E);
        chk("t2_cy",  32'(got_c[0]), 32'h1);
        chk("t2_ov",  32'(got_o[0]), 32'h1);

        // Gaps every third cycle.
        last_seen = 0;
        word(1'b0, WIDTH, 1'b1, 1'b0, 3);
        chk("t4_sum", 32'(got_w[0]), 32'h0000A2E6);
        chk("t4_cy",  32'(got_c[0]), 32'h0);
        chk("t4_ov",  32'(got_o[0]), 32'h0);
        chk("t4_lastcnt", 32'(last_seen), 32'd1);

        // Abort at bit 5, restart, then an unmarked follow-on word.
        last_seen = 0;
        set_ops(16'hFFFF, 16'hFFFF, WIDTH'($urandom), WIDTH'($urandom), 16'h1234, 16'h4321);
        word(1'b1, 5, 1'b1, 1'b0, 0);
        set_ops(16'h0003, 16'h0005, WIDTH'($urandom), WIDTH'($urandom), 16'h8000, 16'h8000);
        word(1'b0, WIDTH, 1'b1, 1'b1, 0);
        chk("t5_sum", 32'(got_w[0]), 32'h00000008);
        chk("t5_lastcnt", 32'(last_seen), 32'd1);
        set_ops(16'h0005, 16'h0007, WIDTH'($urandom), WIDTH'($urandom), WIDTH'($urandom), WIDTH'($urandom));
        word(1'b1, WIDTH, 1'b0, 1'b0, 0);
        chk("t5b_sum", 32'(got_w[0]), 32'h0000FFFE);
        chk("t5b_cy",  32'(got_c[0]), 32'h0);

        // Reset at bit 7 with carries set, then a fresh word.
        set_ops(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        word(1'b0, 7, 1'b1, 1'b0, 0);
        rst = 1'b1;
        beat(1'b1, 1'b0, 1'b1, '1, '1, zero_exp());
        rst = 1'b0;
        set_ops(16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001);
        word(1'b0, WIDTH, 1'b0, 1'b0, 0);
        chk("t6_sum", 32'(got_w[0]), 32'h00000002);
        chk("t6_cy",  32'(got_c[0]), 32'h0);

        bus.in_valid = 1'b0;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
